seed_random_1_data_path_counter: RTL and testbench

Pseudo-random card source for the blackjack seed_random_1 datapath. A free-running mod-52 counter cycles through every card index, one per clock. When the controller raises its card-request state, the block samples the current index and presents the encoded card on `next_card_o`. Randomness comes from the unpredictable timing of player requests relative to the counter.

---
 rtl/seed_random_1_data_path_counter.sv | 91 +++++++++
 tb/tb_seed_random_1_data_path_counter.sv | 136 +++++++++++++
 2 files changed

// File: rtl/seed_random_1_data_path_counter.sv
// Pseudo-random card source: a free-running mod-52 index is sampled on each
// rising card request and presented as an encoded {suit, rank} card.
module seed_random_1_data_path_counter (
    input  logic       clk_dp_c_i,
    input  logic       rst_dp_c_i,
    input  logic       req_card_state_dp_c_i,
    output logic [7:0] next_card_o
);

    localparam int unsigned CntW     = 6;
    localparam int unsigned CardW    = 8;
    localparam int unsigned SuitW    = 2;
    localparam int unsigned RankW    = 4;
    localparam int unsigned PadW     = CardW - SuitW - RankW;
    localparam int unsigned NumCards = 52;
    localparam int unsigned NumRanks = 13;

    typedef struct packed {
        logic [PadW-1:0]  pad;
        logic [SuitW-1:0] suit;
        logic [RankW-1:0] rank;
    } card_t;

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;
    logic            req_q;
    logic            req_d;
    card_t           card_q;
    card_t           card_d;

    logic            rise_c;
    logic [SuitW-1:0] suit_c;
    logic [CntW-1:0]  rem_c;
    card_t           enc_c;

    // Free-running card index, wraps 51 -> 0 regardless of requests.
    always_comb begin
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(NumCards - 1)) begin
            cnt_d = '0;
        end
    end

    // Suit by compare/subtract chain; remainder is the zero-based rank.
    always_comb begin
        suit_c = '0;
        rem_c  = cnt_q;
        if (cnt_q >= CntW'(3 * NumRanks)) begin
            suit_c = SuitW'(3);
            rem_c  = cnt_q - CntW'(3 * NumRanks);
        end else if (cnt_q >= CntW'(2 * NumRanks)) begin
            suit_c = SuitW'(2);
            rem_c  = cnt_q - CntW'(2 * NumRanks);
        end else if (cnt_q >= CntW'(NumRanks)) begin
            suit_c = SuitW'(1);
            rem_c  = cnt_q - CntW'(NumRanks);
        end
    end

    always_comb begin
        enc_c      = '0;
        enc_c.suit = suit_c;
        enc_c.rank = RankW'(rem_c) + RankW'(1);
    end

    assign rise_c = req_card_state_dp_c_i & ~req_q;

    // A card is latched only on the request's rising edge; otherwise it holds.
    always_comb begin
        req_d  = req_card_state_dp_c_i;
        card_d = card_q;
        if (rise_c) begin
            card_d = enc_c;
        end
    end

    always_ff @(posedge clk_dp_c_i) begin
        if (rst_dp_c_i) begin
            cnt_q  <= '0;
            req_q  <= 1'b0;
            card_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            req_q  <= req_d;
            card_q <= card_d;
        end
    end

    assign next_card_o = card_q;

endmodule

// File: tb/tb_seed_random_1_data_path_counter.sv
// Directed bench for the card source: reset, capture encodings, held requests,
// back-to-back pulses and reset while a request is active.
module tb_seed_random_1_data_path_counter;

    logic       clk;
    logic       rst;
    logic       req;
    logic [7:0] card;

    int n_cmp;
    int n_bad;
    int tb_cnt;

    seed_random_1_data_path_counter dut (
        .clk_dp_c_i            (clk),
        .rst_dp_c_i            (rst),
        .req_card_state_dp_c_i (req),
        .next_card_o           (card)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 8'h%02h expected 8'h%02h", tag, got, exp);
        end
    endtask

    // One clock edge; tb_cnt tracks the index the DUT will sample next.
    task automatic tick();
        logic r;
        r = rst;
        @(posedge clk);
        #1;
        if (r) tb_cnt = 0;
        else   tb_cnt = (tb_cnt == 51) ? 0 : tb_cnt + 1;
    endtask

    // Drop request for one edge, run to the target index, then raise it.
    task automatic capture_at(input int target, input logic [7:0] exp, input string tag);
        int guard;
        req = 1'b0;
        tick();
        guard = 0;
        while (tb_cnt != target && guard < 60) begin
            tick();
            guard++;
        end
        if (guard >= 60) check_eq({tag, "_timeout"}, 8'hFF, 8'h00);
        req = 1'b1;
        tick();
        check_eq(tag, card, exp);
        req = 1'b0;
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        tb_cnt = 0;
        rst    = 1'b1;
        req    = 1'b0;

        tick();
        tick();
        check_eq("reset", card, 8'h00);

        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i % 5 == 4) check_eq("idle", card, 8'h00);
        end

        capture_at(5, 8'h06, "cap5");
        req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("hold", card, 8'h06);
        end

        capture_at(0,  8'h01, "cap0");
        capture_at(12, 8'h0D, "cap12");
        capture_at(13, 8'h11, "cap13");
        capture_at(25, 8'h1D, "cap25");
        capture_at(26, 8'h21, "cap26");
        capture_at(51, 8'h3D, "cap51");
        capture_at(38, 8'h2D, "cap38");
        capture_at(39, 8'h31, "cap39");

        // Wrap: from reset, 51 idle edges bring the index to 51.
        rst = 1'b1;
        req = 1'b0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 51; i++) tick();
        req = 1'b1;
        tick();
        check_eq("wrap51", card, 8'h3D);
        req = 1'b0;
        tick();
        check_eq("wrap_hold", card, 8'h3D);
        capture_at(0, 8'h01, "wrap0");

        // Back-to-back pulses 1,0,1 starting at index 10.
        req = 1'b0;
        tick();
        while (tb_cnt != 10) tick();
        req = 1'b1;
        tick();
        check_eq("pulse_a", card, 8'h0B);
        req = 1'b0;
        tick();
        check_eq("pulse_gap", card, 8'h0B);
        req = 1'b1;
        tick();
        check_eq("pulse_b", card, 8'h0D);

        // Reset with request high and a card latched, then release.
        tick();
        check_eq("held_pre_rst", card, 8'h0D);
        rst = 1'b1;
        tick();
        check_eq("mid_reset", card, 8'h00);
        rst = 1'b0;
        tick();
        check_eq("post_reset_cap", card, 8'h01);
        tick();
        check_eq("post_reset_hold", card, 8'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
